// File: rtl/fpu_tag_buffer.sv
// Tag manager in front of the FPU: allocates tags, holds per-tag metadata, re-associates out-of-order completions.
// Optional per-lane fflags merge is compiled in when FPU_TAG_BUFFER_FFLAGS_EN is defined.
module fpu_tag_buffer #(
    parameter int TAGW   = 4,
    parameter int META_W = 40,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [META_W-1:0]     req_meta,
    input  logic [LANES-1:0]      req_tmask,
    output logic                  fpu_valid_in,
    input  logic                  fpu_ready_in,
    output logic [TAGW-1:0]       fpu_tag_in,
    input  logic                  fpu_valid_out,
    output logic                  fpu_ready_out,
    input  logic [TAGW-1:0]       fpu_tag_out,
    input  logic [LANES*32-1:0]   fpu_result,
    input  logic                  fpu_has_fflags,
    input  logic [LANES*5-1:0]    fpu_fflags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [META_W-1:0]     rsp_meta,
    output logic [LANES-1:0]      rsp_tmask,
    output logic [LANES*32-1:0]   rsp_result,
    output logic                  rsp_has_fflags,
    output logic [4:0]            rsp_fflags,
    output logic                  busy
);
    localparam int DEPTH   = 1 << TAGW;
    localparam int ENTRY_W = META_W + LANES;
    localparam logic [TAGW:0] CNT_ONE  = (TAGW+1)'(1);
    localparam logic [TAGW:0] CNT_FULL = (TAGW+1)'(DEPTH);

    logic [DEPTH-1:0]    r_used;
    logic [TAGW:0]       r_count;
    logic [ENTRY_W-1:0]  r_ram [DEPTH];
    logic [ENTRY_W-1:0]  r_rsp_entry;
    logic [LANES*32-1:0] r_rsp_result;
    logic                r_rsp_valid;
    logic [TAGW-1:0]     w_alloc_tag;
    logic                w_full;
    logic                w_issue_fire;
    logic                w_cmpl_fire;

    // Lowest free index wins; scanning downward lets the last hit be the smallest.
    always_comb begin
        w_alloc_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_used[i]) w_alloc_tag = TAGW'(i);
        end
    end

    assign w_full        = (r_count == CNT_FULL);
    assign fpu_valid_in  = req_valid && !w_full;
    assign req_ready     = fpu_ready_in && !w_full;
    assign fpu_tag_in    = w_alloc_tag;
    assign w_issue_fire  = req_valid && req_ready;
    assign fpu_ready_out = !r_rsp_valid || rsp_ready;
    assign w_cmpl_fire   = fpu_valid_out && fpu_ready_out;
    assign busy          = (r_count != '0);

    // A tag being issued is free and a tag completing is in use, so one bit never sees both.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_used
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_used[gi] <= 1'b0;
                end else if (w_cmpl_fire && (fpu_tag_out == TAGW'(gi))) begin
                    r_used[gi] <= 1'b0;
                end else if (w_issue_fire && (w_alloc_tag == TAGW'(gi))) begin
                    r_used[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_issue_fire, w_cmpl_fire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Metadata table with registered read straight into the response register.
    always_ff @(posedge clk) begin
        if (w_issue_fire) r_ram[w_alloc_tag] <= {req_meta, req_tmask};
        if (w_cmpl_fire) begin
            r_rsp_entry  <= r_ram[fpu_tag_out];
            r_rsp_result <= fpu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
        end else if (w_cmpl_fire) begin
            r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_meta   = r_rsp_entry[ENTRY_W-1:LANES];
    assign rsp_tmask  = r_rsp_entry[LANES-1:0];
    assign rsp_result = r_rsp_result;

`ifdef FPU_TAG_BUFFER_FFLAGS_EN
    logic                 r_rsp_has_fflags;
    logic [LANES*5-1:0]   r_rsp_fflags_raw;
    logic [LANES*5-1:0]   w_masked;
    logic [4:0]           w_merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_has_fflags <= 1'b0;
            r_rsp_fflags_raw <= '0;
        end else if (w_cmpl_fire) begin
            r_rsp_has_fflags <= fpu_has_fflags;
            r_rsp_fflags_raw <= fpu_fflags;
        end
    end

    // Raw lane flags are kept and masked with the stored tmask on the way out.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mask
            assign w_masked[gi*5 +: 5] = r_rsp_fflags_raw[gi*5 +: 5] & {5{rsp_tmask[gi]}};
        end
    endgenerate

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < LANES; i++) begin
            w_merged = w_merged | w_masked[i*5 +: 5];
        end
    end

    assign rsp_has_fflags = r_rsp_has_fflags;
    assign rsp_fflags     = r_rsp_has_fflags ? w_merged : 5'b0;
`else
    logic w_unused_fflags;
    assign w_unused_fflags = ^{fpu_fflags, fpu_has_fflags};
    assign rsp_has_fflags  = 1'b0;
    assign rsp_fflags      = 5'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_cmpl_fire) begin
            assert (r_used[fpu_tag_out]);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_tag_buffer.sv
// Scoreboard bench for fpu_tag_buffer: expected responses queued at completion, checked when writeback accepts them.
module tb_fpu_tag_buffer;
    localparam int TAGW = 4, META_W = 40, LANES = 4;
`ifdef FPU_TAG_BUFFER_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                req_valid, req_ready;
    logic [META_W-1:0]   req_meta;
    logic [LANES-1:0]    req_tmask;
    logic                fpu_valid_in, fpu_ready_in;
    logic [TAGW-1:0]     fpu_tag_in;
    logic                fpu_valid_out, fpu_ready_out;
    logic [TAGW-1:0]     fpu_tag_out;
    logic [LANES*32-1:0] fpu_result;
    logic                fpu_has_fflags;
    logic [LANES*5-1:0]  fpu_fflags;
    logic                rsp_valid, rsp_ready;
    logic [META_W-1:0]   rsp_meta;
    logic [LANES-1:0]    rsp_tmask;
    logic [LANES*32-1:0] rsp_result;
    logic                rsp_has_fflags;
    logic [4:0]          rsp_fflags;
    logic                busy;

    fpu_tag_buffer #(.TAGW(TAGW), .META_W(META_W), .LANES(LANES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_meta(req_meta), .req_tmask(req_tmask),
        .fpu_valid_in(fpu_valid_in), .fpu_ready_in(fpu_ready_in), .fpu_tag_in(fpu_tag_in),
        .fpu_valid_out(fpu_valid_out), .fpu_ready_out(fpu_ready_out), .fpu_tag_out(fpu_tag_out),
        .fpu_result(fpu_result), .fpu_has_fflags(fpu_has_fflags), .fpu_fflags(fpu_fflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_meta(rsp_meta), .rsp_tmask(rsp_tmask),
        .rsp_result(rsp_result), .rsp_has_fflags(rsp_has_fflags), .rsp_fflags(rsp_fflags),
        .busy(busy)
    );

    typedef struct packed {
        logic [META_W-1:0]   meta;
        logic [LANES-1:0]    tmask;
        logic [LANES*32-1:0] result;
        logic                has;
        logic [4:0]          ff;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int checks = 0;
    int errors = 0;
    logic [META_W-1:0] meta_m  [16];
    logic [LANES-1:0]  tmask_m [16];

    function automatic rsp_t mk_exp(input int tag, input logic [LANES*32-1:0] res,
                                    input logic has, input logic [4:0] ff);
        rsp_t e;
        e.meta = meta_m[tag]; e.tmask = tmask_m[tag]; e.result = res; e.has = has; e.ff = ff;
        return e;
    endfunction

    // Response monitor: samples mid-cycle, after the driver has settled this cycle's inputs.
    always begin
        @(negedge clk);
        #2;
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            $display("rsp meta=%h tmask=%b has=%b ff=%b", rsp_meta, rsp_tmask, rsp_has_fflags, rsp_fflags);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got meta=%h required no response", rsp_meta);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_meta, rsp_tmask, rsp_result, rsp_has_fflags, rsp_fflags} !== mon_e) begin
                    errors++;
                    $display("FAIL rsp_data got meta=%h tmask=%b has=%b ff=%b required meta=%h tmask=%b has=%b ff=%b",
                             rsp_meta, rsp_tmask, rsp_has_fflags, rsp_fflags,
                             mon_e.meta, mon_e.tmask, mon_e.has, mon_e.ff);
                end
            end
        end
    end

    task automatic new_req(input int tag, input logic [LANES-1:0] tm);
        req_valid = 1'b1;
        req_meta  = {8'($urandom), $urandom};
        req_tmask = tm;
        meta_m[tag]  = req_meta;
        tmask_m[tag] = tm;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b required 0", rsp_valid); end
        checks++; if (rsp_has_fflags !== 1'b0 || rsp_fflags !== 5'b0) begin
            errors++; $display("FAIL reset_fflags got %b/%b required 0/0", rsp_has_fflags, rsp_fflags); end
        checks++; if (fpu_tag_in !== 4'd0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_alloc got tag=%0d ready=%b required 0/1", fpu_tag_in, req_ready); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            new_req(i, 4'($urandom_range(1, 15)));
            #1;
            checks++;
            if (fpu_tag_in !== 4'(i) || req_ready !== 1'b1 || fpu_valid_in !== 1'b1) begin
                errors++;
                $display("FAIL fill_tag got tag=%0d ready=%b valid_in=%b required %0d/1/1",
                         fpu_tag_in, req_ready, fpu_valid_in, i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || fpu_valid_in !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got ready=%b valid_in=%b busy=%b required 0/0/1", req_ready, fpu_valid_in, busy);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_out_of_order();
        int order [3] = '{5, 2, 9};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== (k != 0)) begin
                errors++; $display("FAIL ooo_latency got rsp_valid=%b required %b", rsp_valid, k != 0);
            end
            fpu_valid_out  = 1'b1;
            fpu_tag_out    = 4'(order[k]);
            fpu_result     = {$urandom, $urandom, $urandom, $urandom};
            fpu_has_fflags = 1'b0;
            fpu_fflags     = 20'($urandom);
            #1;
            checks++;
            if (fpu_ready_out !== 1'b1) begin
                errors++; $display("FAIL ooo_ready_out got %b required 1", fpu_ready_out);
            end
            exp_q.push_back(mk_exp(order[k], fpu_result, 1'b0, 5'b0));
        end
        @(negedge clk);
        fpu_valid_out = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ooo_last_valid got %b required 1", rsp_valid); end
        @(negedge clk);
        new_req(2, 4'b1111);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ooo_drained got %b required 0", rsp_valid); end
        checks++;
        if (fpu_tag_in !== 4'd2 || req_ready !== 1'b1) begin
            errors++; $display("FAIL ooo_next_alloc got tag=%0d ready=%b required 2/1", fpu_tag_in, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        new_req(5, 4'b0011);
        #1;
        checks++; if (fpu_tag_in !== 4'd5) begin errors++; $display("FAIL b2b_tag5 got %0d required 5", fpu_tag_in); end
        @(negedge clk);
        new_req(9, 4'b1100);
        #1;
        checks++; if (fpu_tag_in !== 4'd9) begin errors++; $display("FAIL b2b_tag9 got %0d required 9", fpu_tag_in); end
        // Table full: complete tag 3 while a request waits; it must not issue this cycle.
        @(negedge clk);
        req_meta      = {8'($urandom), $urandom};
        fpu_valid_out = 1'b1;
        fpu_tag_out   = 4'd3;
        fpu_result    = {$urandom, $urandom, $urandom, $urandom};
        #1;
        checks++;
        if (req_ready !== 1'b0 || fpu_valid_in !== 1'b0 || fpu_ready_out !== 1'b1) begin
            errors++; $display("FAIL b2b_same_cycle got ready=%b valid_in=%b ready_out=%b required 0/0/1",
                               req_ready, fpu_valid_in, fpu_ready_out);
        end
        exp_q.push_back(mk_exp(3, fpu_result, 1'b0, 5'b0));
        // Tag 3 now issues while tag 0 completes in the same cycle.
        @(negedge clk);
        fpu_tag_out = 4'd0;
        fpu_result  = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(mk_exp(0, fpu_result, 1'b0, 5'b0));
        new_req(3, 4'b0110);
        #1;
        checks++;
        if (fpu_tag_in !== 4'd3 || req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_reissue got tag=%0d ready=%b required 3/1", fpu_tag_in, req_ready);
        end
        @(negedge clk);
        fpu_valid_out = 1'b0;
        req_valid     = 1'b0;
        #1;
        checks++;
        if (fpu_tag_in !== 4'd0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_count got tag=%0d ready=%b required 0/1", fpu_tag_in, req_ready);
        end
    endtask

    task automatic test_fflags();
        logic [4:0] exp_ff;
        exp_ff = FF_EN ? 5'b10100 : 5'b00000;
        @(negedge clk);
        new_req(0, 4'b0101);
        @(negedge clk);
        req_valid      = 1'b0;
        fpu_valid_out  = 1'b1;
        fpu_tag_out    = 4'd0;
        fpu_result     = {$urandom, $urandom, $urandom, $urandom};
        fpu_has_fflags = 1'b1;
        fpu_fflags     = {5'b00001, 5'b00100, 5'b01000, 5'b10000};
        exp_q.push_back(mk_exp(0, fpu_result, FF_EN, exp_ff));
        @(negedge clk);
        fpu_valid_out = 1'b0;
        new_req(0, 4'b0101);
        #1;
        checks++;
        if (rsp_fflags !== exp_ff) begin
            errors++; $display("FAIL fflags_merge got %b required %b", rsp_fflags, exp_ff);
        end
        @(negedge clk);
        req_valid      = 1'b0;
        fpu_valid_out  = 1'b1;
        fpu_result     = {$urandom, $urandom, $urandom, $urandom};
        fpu_has_fflags = 1'b0;
        exp_q.push_back(mk_exp(0, fpu_result, 1'b0, 5'b0));
        @(negedge clk);
        fpu_valid_out = 1'b0;
        #1;
        checks++;
        if (rsp_fflags !== 5'b0 || rsp_has_fflags !== 1'b0) begin
            errors++; $display("FAIL fflags_none got %b/%b required 0/0", rsp_has_fflags, rsp_fflags);
        end
    endtask

    task automatic test_backpressure();
        logic [META_W-1:0]   old_meta;
        logic [LANES*32-1:0] old_res;
        @(negedge clk);
        new_req(0, 4'b1001);
        @(negedge clk);
        req_valid     = 1'b0;
        rsp_ready     = 1'b0;
        fpu_valid_out = 1'b1;
        fpu_tag_out   = 4'd1;
        fpu_result    = {$urandom, $urandom, $urandom, $urandom};
        old_meta      = meta_m[1];
        old_res       = fpu_result;
        exp_q.push_back(mk_exp(1, fpu_result, 1'b0, 5'b0));
        @(negedge clk);
        fpu_tag_out = 4'd4;
        fpu_result  = {$urandom, $urandom, $urandom, $urandom};
        new_req(1, 4'b1111);
        #1;
        checks++;
        if (fpu_tag_in !== 4'd1 || req_ready !== 1'b1 || fpu_ready_out !== 1'b0) begin
            errors++; $display("FAIL bp_refill got tag=%0d ready=%b ready_out=%b required 1/1/0",
                               fpu_tag_in, req_ready, fpu_ready_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (fpu_ready_out !== 1'b0 || rsp_valid !== 1'b1 || rsp_meta !== old_meta ||
                rsp_result !== old_res || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall got ready_out=%b valid=%b meta=%h req_ready=%b required 0/1/%h/0",
                                   fpu_ready_out, rsp_valid, rsp_meta, req_ready, old_meta);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (fpu_ready_out !== 1'b1) begin errors++; $display("FAIL bp_release got %b required 1", fpu_ready_out); end
        exp_q.push_back(mk_exp(4, fpu_result, 1'b0, 5'b0));
        @(negedge clk);
        fpu_tag_out = 4'd6;
        fpu_result  = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(mk_exp(6, fpu_result, 1'b0, 5'b0));
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || fpu_ready_out !== 1'b1) begin
            errors++; $display("FAIL bp_drain got valid=%b ready_out=%b required 1/1", rsp_valid, fpu_ready_out);
        end
        @(negedge clk);
        fpu_valid_out = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_last got %b required 1", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b required 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            new_req(i, 4'b0001);
        end
        @(negedge clk);
        req_valid     = 1'b0;
        rsp_ready     = 1'b0;
        fpu_valid_out = 1'b1;
        fpu_tag_out   = 4'd2;
        @(negedge clk);
        fpu_valid_out = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre got busy=%b valid=%b required 1/1", busy, rsp_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || fpu_tag_in !== 4'd0 || req_ready !== 1'b1 ||
            rsp_has_fflags !== 1'b0 || rsp_fflags !== 5'b0) begin
            errors++; $display("FAIL mid_reset got busy=%b valid=%b tag=%0d ready=%b required 0/0/0/1",
                               busy, rsp_valid, fpu_tag_in, req_ready);
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got no finish required finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_meta = '0; req_tmask = '0;
        fpu_ready_in = 1'b1; fpu_valid_out = 1'b0; fpu_tag_out = '0; fpu_result = '0;
        fpu_has_fflags = 1'b0; fpu_fflags = '0; rsp_ready = 1'b1;
        test_reset();
        test_fill();
        test_out_of_order();
        test_back_to_back();
        test_fflags();
        test_backpressure();
        test_reset_mid();
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_tag_buffer.md
# fpu_tag_buffer

Request/response tag manager placed directly upstream of the FPU core wrapper (the FMA/DIV/SQRT/CVT/NCP dispatch block). Allocates a free TAGW-bit tag per accepted request, stores its metadata and thread mask, and passes the request to the FPU. Matches each completion returned out of order by `tag_out` back to its metadata, merges per-lane fflags over active lanes, and presents a registered response to writeback.

## Interface
- TAGW, 4, tag width; table depth DEPTH = 2^TAGW
- META_W, 40, opaque metadata width (warp id, PC, rd, wb flag)
- LANES, `NUM_THREADS, lanes per request

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_meta  in  META_W  metadata to store
- req_tmask  in  LANES  active-lane mask to store
- fpu_valid_in  out  1  to FPU valid_in
- fpu_ready_in  in  1  from FPU ready_in
- fpu_tag_in  out  TAGW  allocated tag, to FPU tag_in
- fpu_valid_out  in  1  FPU completion valid
- fpu_ready_out  out  1  completion accepted
- fpu_tag_out  in  TAGW  completion tag
- fpu_result  in  LANES*32  completion result
- fpu_has_fflags  in  1  completion carries flags
- fpu_fflags  in  LANES*5  per-lane fflags {NV,DZ,OF,UF,NX}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  writeback ready
- rsp_meta  out  META_W  stored metadata
- rsp_tmask  out  LANES  stored mask
- rsp_result  out  LANES*32  registered result
- rsp_has_fflags  out  1  registered has_fflags
- rsp_fflags  out  5  merged flags
- busy  out  1  any tag outstanding

## Operation
- State: valid bitvector `used[DEPTH]`, meta/tmask RAM of DEPTH entries, outstanding counter `count` (TAGW+1 bits), one response register.
- Allocation: alloc tag = lowest index with used==0 (priority encoder). full = (count == DEPTH).
- Issue: fpu_valid_in = req_valid && !full; req_ready = fpu_ready_in && !full; fpu_tag_in = alloc tag. Operands are routed to the FPU outside this block; this block only gates the handshake.
- On issue fire: used[alloc] <= 1, RAM[alloc] <= {req_meta, req_tmask}.
- Completion: fpu_ready_out = !rsp_valid || rsp_ready. On fire: load rsp register with RAM[fpu_tag_out], fpu_result, fpu_has_fflags, merged flags; used[fpu_tag_out] <= 0.
- Flag merge: rsp_fflags = bitwise OR over lanes i where tmask[i]=1 of fpu_fflags[i]; 0 when has_fflags=0.
- count: +1 on issue only, -1 on completion only, unchanged on both or neither.
- busy = (count != 0).
- Simultaneous issue and completion: legal. The freed tag is not eligible for allocation until the next cycle. Issue to the same tag in that cycle is impossible because used=1.
- Completion on a tag with used==0 is a protocol error: simulation assertion fires; RTL behaviour is undefined.
- Reset: used all 0, count 0, rsp_valid 0, rsp_has_fflags 0, rsp_fflags 0. RAM is not reset.
- Reset mid-operation discards all outstanding tags. FPU is reset in the same cycle by the parent.

## Timing
- Issue path is combinational: 0-cycle req→fpu handshake.
- Completion to rsp_valid: 1 cycle (registered).
- Full throughput: 1 completion/cycle while rsp_ready=1. Response register holds when rsp_valid && !rsp_ready.
- Response outputs are stable while rsp_valid && !rsp_ready.
- Maximum outstanding requests: DEPTH.

## Configuration
- `FPU_TAG_BUFFER_FFLAGS_EN` defined: flag merge logic as above.
- Not defined: fpu_fflags and fpu_has_fflags are ignored; rsp_fflags and rsp_has_fflags are tied to 0.

## Test plan
- Reset, then 16 back-to-back requests with fpu_ready_in=1 and no completions → fpu_tag_in 0..15, then full, req_ready=0, count=16, busy=1.
- Completions returned in order 5, 2, 9 → rsp_meta equals the meta stored for tags 5, 2, 9 respectively, each 1 cycle later; next allocation is tag 2.
- Issue and completion of tag 3 in the same cycle with only tag 3 free → no issue that cycle; tag 3 issued the following cycle; count unchanged across the pair.
- tmask=4'b0101, lane flags NV/DZ/OF/NX on lanes 0..3, has_fflags=1 → rsp_fflags={NV,0,OF,0,0}; with has_fflags=0 → rsp_fflags=0.
- rsp_ready=0 for 3 cycles with completions pending → fpu_ready_out=0, rsp outputs stable, no tag released; on release, completions drain 1/cycle.
- Assert reset with 7 tags outstanding → next cycle count=0, busy=0, rsp_valid=0, alloc tag=0.
